mem_addr_arb: RTL and testbench

MEM_ADDR_ARB -- requirements
Module: mem_addr_arb

---
 rtl/mem_addr_arb.sv | 126 ++++++++++++
 tb/tb_mem_addr_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_arb.sv
// Round-robin arbiter for a shared bus fronted by a quad 2:1 mux bank.
// Select settles one clock before the strobe; every output is a flop.
module mem_addr_arb #(
    parameter int HOLD_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic done,
    output logic mux_sel,
    output logic mux_enb_n,
    output logic busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Counter runs from HOLD_LOAD down to 0, so HOLD lasts HOLD_LOAD+1 clocks; 0 maps to 1.
    localparam int         HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : ((HOLD_CYCLES > 15) ? 15 : HOLD_CYCLES);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_EFF - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       done_q, done_d;
    logic       mux_sel_q, mux_sel_d;
    logic       mux_enb_n_q, mux_enb_n_d;
    logic       busy_q, busy_d;
    logic       winner;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_a_d     = gnt_a_q;
        gnt_b_d     = gnt_b_q;
        done_d      = done_q;
        mux_sel_d   = mux_sel_q;
        mux_enb_n_d = mux_enb_n_q;
        busy_d      = busy_q;
        winner      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    // Contention goes to whoever was not served last.
                    winner    = (req_a && req_b) ? ~last_q : req_b;
                    state_d   = ST_SETUP;
                    last_d    = winner;
                    mux_sel_d = winner;
                    gnt_a_d   = ~winner;
                    gnt_b_d   = winner;
                    busy_d    = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d     = ST_HOLD;
                cnt_d       = HOLD_LOAD;
                mux_enb_n_d = 1'b0;
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_DONE;
                    mux_enb_n_d = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_a_d = 1'b0;
                gnt_b_d = 1'b0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_a_d     = 1'b0;
                gnt_b_d     = 1'b0;
                done_d      = 1'b0;
                mux_enb_n_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            last_q      <= 1'b0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            done_q      <= 1'b0;
            mux_sel_q   <= 1'b0;
            mux_enb_n_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            done_q      <= done_d;
            mux_sel_q   <= mux_sel_d;
            mux_enb_n_q <= mux_enb_n_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign done      = done_q;
    assign mux_sel   = mux_sel_q;
    assign mux_enb_n = mux_enb_n_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_addr_arb.sv
// Scoreboard bench for mem_addr_arb: three instances (HOLD_CYCLES 3, 0, 15)
// share stimulus; an access-level model predicts every cycle's outputs.
module tb_mem_addr_arb;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset;
    logic req_a, req_b;
    logic [NI-1:0] ga, gb, dn, ms, en, bz;

    mem_addr_arb #(.HOLD_CYCLES(3)) u_dut0 (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .gnt_a(ga[0]), .gnt_b(gb[0]), .done(dn[0]), .mux_sel(ms[0]),
        .mux_enb_n(en[0]), .busy(bz[0]));
    mem_addr_arb #(.HOLD_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .gnt_a(ga[1]), .gnt_b(gb[1]), .done(dn[1]), .mux_sel(ms[1]),
        .mux_enb_n(en[1]), .busy(bz[1]));
    mem_addr_arb #(.HOLD_CYCLES(15)) u_dut2 (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
        .gnt_a(ga[2]), .gnt_b(gb[2]), .done(dn[2]), .mux_sel(ms[2]),
        .mux_enb_n(en[2]), .busy(bz[2]));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: one access at a time per instance.
    bit last [NI];
    bit w    [NI];
    bit sel  [NI];
    int nf   [NI];
    int st   [NI];
    int e;
    logic [6*NI-1:0] sbq[$];

    logic probe = 1'b0;
    int   probe_kind = 0;

    function automatic int heff(input int i);
        case (i)
            0:       return 3;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            last[i] = 1'b0;
            w[i]    = 1'b0;
            sel[i]  = 1'b0;
            nf[i]   = 0;
            st[i]   = -1000;
        end
    endtask

    // Drive requests, let one edge sample them, then queue the predicted outputs.
    task automatic step(input bit ra, input bit rb);
        logic [6*NI-1:0] ex;
        logic [5:0]      v;
        int              h;
        int              o;
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        ex = '0;
        for (int i = 0; i < NI; i++) begin
            h = heff(i);
            if (e >= nf[i] && (ra || rb)) begin
                w[i]    = (ra && rb) ? ~last[i] : rb;
                last[i] = w[i];
                sel[i]  = w[i];
                st[i]   = e;
                nf[i]   = e + h + 3;
            end
            o = e - st[i];
            if (o >= 0 && o <= h + 1)
                v = {~w[i], w[i], (o == h + 1), sel[i], ~(o >= 1 && o <= h), 1'b1};
            else
                v = {1'b0, 1'b0, 1'b0, sel[i], 1'b1, 1'b0};
            ex[i*6 +: 6] = v;
        end
        sbq.push_back(ex);
        e++;
        #1;
    endtask

    task automatic pulse(input int k);
        probe_kind = k;
        probe = 1'b1;
        #1;
        probe = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    // Monitor: pops one expectation per cycle and checks invariants.
    logic [NI-1:0] prev_low;
    logic [NI-1:0] prev_ms;
    always @(negedge clk or posedge probe) begin
        logic [6*NI-1:0] ex;
        logic [5:0]      obs;
        if (probe) begin
            if (probe_kind == 0) begin
                for (int i = 0; i < NI; i++) begin
                    obs = {ga[i], gb[i], dn[i], ms[i], en[i], bz[i]};
                    checks++;
                    if (obs !== 6'b000010) begin
                        errors++;
                        $display("FAIL reset_vals inst%0d got %b want 000010 t=%0t", i, obs, $time);
                    end
                end
            end else begin
                checks++;
                if (sbq.size() != 0) begin
                    errors++;
                    $display("FAIL drain got %0d pending want 0", sbq.size());
                end
            end
        end else if (reset) begin
            prev_low = '0;
        end else begin
            if (sbq.size() > 0) begin
                ex = sbq.pop_front();
                for (int i = 0; i < NI; i++) begin
                    obs = {ga[i], gb[i], dn[i], ms[i], en[i], bz[i]};
                    checks++;
                    if (obs !== ex[i*6 +: 6]) begin
                        errors++;
                        $display("FAIL outputs inst%0d got %b want %b t=%0t", i, obs, ex[i*6 +: 6], $time);
                    end
                end
            end
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (ga[i] && gb[i]) begin
                    errors++;
                    $display("FAIL gnt_excl inst%0d got both high want at most one t=%0t", i, $time);
                end
                if (prev_low[i] && !en[i]) begin
                    checks++;
                    if (ms[i] !== prev_ms[i]) begin
                        errors++;
                        $display("FAIL sel_stable inst%0d got %b want %b t=%0t", i, ms[i], prev_ms[i], $time);
                    end
                end
            end
            prev_low = ~en;
            prev_ms  = ms;
        end
    end

    initial begin
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        e = 0;
        model_reset();
        #2;
        pulse(0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single request then early drop: one full access, one done.
        step(1'b1, 1'b0);
        idle(20);

        // Both held: alternating B, A, B, A.
        for (int k = 0; k < 80; k++) step(1'b1, 1'b1);
        idle(20);

        // Late requester during A's access.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b0, 1'b1);
        idle(20);

        // Reset during the 2nd HOLD clock of the HOLD_CYCLES=3 instance.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        pulse(0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        idle(3);
        step(1'b1, 1'b0);
        idle(20);

        // Randomized traffic.
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        idle(20);

        @(negedge clk);
        #1;
        pulse(1);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
